// File: rtl/nec_ir_frame_decoder_pkg.sv
// nec_ir_frame_decoder_pkg: state encoding, tick windows and frame byte offsets for the NEC decoder
package nec_ir_frame_decoder_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REPEAT_MARK
  } state_t;
  localparam int LEAD_MARK_MIN = 108;
  localparam int LEAD_MARK_MAX = 148;
  localparam int LEAD_SPACE_MIN = 54;
  localparam int LEAD_SPACE_MAX = 74;
  localparam int REPEAT_SPACE_MIN = 27;
  localparam int REPEAT_SPACE_MAX = 37;
  localparam int MARK_MIN = 5;
  localparam int MARK_MAX = 11;
  localparam int ZERO_SPACE_MIN = 5;
  localparam int ZERO_SPACE_MAX = 11;
  localparam int ONE_SPACE_MIN = 18;
  localparam int ONE_SPACE_MAX = 30;
  localparam int ADDR_LO_OFS = 0;
  localparam int ADDR_HI_OFS = 8;
  localparam int CMD_OFS = 16;
  localparam int CMD_INV_OFS = 24;
  function automatic logic in_win(input int v, input int lo, input int hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/nec_ir_frame_decoder_tick_filter.sv
// nec_ir_frame_decoder_tick_filter: synchronizer, tick prescaler and glitch filter producing level/edge
module nec_ir_frame_decoder_tick_filter #(
  parameter int DIV_W = 16,
  parameter int FILT_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             pol,
  input  logic             ir_in,
  output logic             tick,
  output logic             level,
  output logic             fedge
);
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [1:0] sync;
  logic [DIV_W-1:0] pcnt;
  logic [FW-1:0] fcnt;
  logic mark, wrap;
  assign mark = sync[1] ^ ~pol;
  assign wrap = pcnt >= div;
  always_ff @(posedge clk) sync <= {sync[0], ir_in};
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      fcnt <= '0;
      tick <= 1'b0;
      level <= 1'b0;
      fedge <= 1'b0;
    end else begin
      pcnt <= wrap ? '0 : pcnt + 1'b1;
      tick <= wrap;
      fedge <= 1'b0;
      if (wrap) begin
        if (mark == level) fcnt <= '0;
        else if (fcnt == FW'(FILT_LEN - 1)) begin
          level <= mark;
          fedge <= 1'b1;
          fcnt <= '0;
        end else fcnt <= fcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/nec_ir_frame_decoder.sv
// nec_ir_frame_decoder: NEC IR decoder measuring filtered segments and strobing frame/repeat/error
module nec_ir_frame_decoder
  import nec_ir_frame_decoder_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int FILT_LEN = 2,
  parameter int DIV_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_tick_div,
  input  logic             cfg_polarity,
  input  logic             cfg_strict_addr,
  input  logic             ir_in,
  output logic             frame_valid,
  output logic             repeat_valid,
  output logic             frame_error,
  output logic [15:0]      addr,
  output logic [7:0]       cmd
);
  logic [DIV_W-1:0] div_q;
  logic pol_q, strict_q, tick, level, fedge, last_ok;
  state_t state;
  logic [CNT_W-1:0] seg;
  logic [4:0] idx;
  logic [31:0] frame;
  logic [7:0] b0, b1, b2, b3;
  logic sat, lm_ok, ls_ok, rs_ok, mk_ok, sp_ok, os_ok, good;
  assign b0 = frame[ADDR_LO_OFS +: 8];
  assign b1 = frame[ADDR_HI_OFS +: 8];
  assign b2 = frame[CMD_OFS +: 8];
  assign b3 = frame[CMD_INV_OFS +: 8];
  assign sat = &seg;
  assign lm_ok = in_win(int'(seg), LEAD_MARK_MIN, LEAD_MARK_MAX);
  assign ls_ok = in_win(int'(seg), LEAD_SPACE_MIN, LEAD_SPACE_MAX);
  assign rs_ok = in_win(int'(seg), REPEAT_SPACE_MIN, REPEAT_SPACE_MAX);
  assign mk_ok = in_win(int'(seg), MARK_MIN, MARK_MAX);
  assign os_ok = in_win(int'(seg), ONE_SPACE_MIN, ONE_SPACE_MAX);
  assign sp_ok = os_ok || in_win(int'(seg), ZERO_SPACE_MIN, ZERO_SPACE_MAX);
  assign good = mk_ok && b3 == ~b2 && (!strict_q || b1 == ~b0);
  nec_ir_frame_decoder_tick_filter #(
    .DIV_W(DIV_W),
    .FILT_LEN(FILT_LEN)
  ) u_filt (
    .clk(wb_clk_i),
    .rst(wb_rst_i || !en),
    .div(div_q),
    .pol(pol_q),
    .ir_in(ir_in),
    .tick(tick),
    .level(level),
    .fedge(fedge)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !en) begin
      state <= IDLE;
      seg <= '0;
      idx <= '0;
      frame <= '0;
      last_ok <= 1'b0;
      frame_valid <= 1'b0;
      repeat_valid <= 1'b0;
      frame_error <= 1'b0;
      div_q <= cfg_tick_div;
      pol_q <= cfg_polarity;
      strict_q <= cfg_strict_addr;
      if (wb_rst_i) begin
        addr <= '0;
        cmd <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      repeat_valid <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE) begin
        div_q <= cfg_tick_div;
        pol_q <= cfg_polarity;
        strict_q <= cfg_strict_addr;
      end
      if (fedge) seg <= '0;
      else if (tick && !sat) seg <= seg + 1'b1;
      if (fedge) begin
        case (state)
          IDLE: state <= level ? LEAD_MARK : IDLE;
          LEAD_MARK: begin
            state <= lm_ok ? LEAD_SPACE : IDLE;
            frame_error <= !lm_ok;
            last_ok <= last_ok && lm_ok;
          end
          LEAD_SPACE: begin
            state <= ls_ok ? BIT_MARK : rs_ok ? REPEAT_MARK : IDLE;
            idx <= '0;
            frame_error <= !(ls_ok || rs_ok);
            last_ok <= last_ok && (ls_ok || rs_ok);
          end
          BIT_MARK: begin
            state <= mk_ok ? BIT_SPACE : IDLE;
            frame_error <= !mk_ok;
            last_ok <= last_ok && mk_ok;
          end
          BIT_SPACE: begin
            state <= !sp_ok ? IDLE : &idx ? STOP_MARK : BIT_MARK;
            frame[idx] <= os_ok;
            idx <= idx + 1'b1;
            frame_error <= !sp_ok;
            last_ok <= last_ok && sp_ok;
          end
          STOP_MARK: begin
            state <= IDLE;
            frame_valid <= good;
            frame_error <= !good;
            last_ok <= good;
            if (good) begin
              addr <= strict_q ? {8'h00, b0} : {b1, b0};
              cmd <= b2;
            end
          end
          REPEAT_MARK: begin
            state <= IDLE;
            repeat_valid <= mk_ok && last_ok;
            frame_error <= !mk_ok;
            last_ok <= last_ok && mk_ok;
          end
          default: state <= IDLE;
        endcase
      end else if (sat && state != IDLE) begin
        state <= IDLE;
        frame_error <= 1'b1;
        last_ok <= 1'b0;
      end
    end
  end
endmodule
